// File: rtl/lsu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_pkg
// Brief    : Shared LSU op-field encodings, FSM state codes and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_mem_pkg;

    localparam int c_op_store_bit = 3;
    localparam int c_op_uns_bit   = 2;

    localparam logic [1:0] c_sz_b = 2'b00;
    localparam logic [1:0] c_sz_h = 2'b01;
    localparam logic [1:0] c_sz_w = 2'b10;
    localparam logic [1:0] c_sz_d = 2'b11;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            c_sz_b:  size_mask = 8'h01;
            c_sz_h:  size_mask = 8'h03;
            c_sz_w:  size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] lo, input logic [1:0] sz);
        case (sz)
            c_sz_b:  is_misaligned = 1'b0;
            c_sz_h:  is_misaligned = lo[0];
            c_sz_w:  is_misaligned = |lo[1:0];
            default: is_misaligned = |lo;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ext.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ext
// Brief    : Load lane select, size truncation and sign/zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ext
    import lsu_mem_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [63:0] data
);

    logic [63:0] w_shifted;

    assign w_shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = w_shifted;
        case (size)
            c_sz_b:  data = uns ? {56'd0, w_shifted[7:0]}  : {{56{w_shifted[7]}},  w_shifted[7:0]};
            c_sz_h:  data = uns ? {48'd0, w_shifted[15:0]} : {{48{w_shifted[15]}}, w_shifted[15:0]};
            c_sz_w:  data = uns ? {32'd0, w_shifted[31:0]} : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default: data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem
// Brief    : Single-outstanding load/store unit bridging execute to a 64-bit bus.
//            Define LSU_MISALIGN_CHECK_EN to fault size-misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem
    import lsu_mem_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [7:0]        mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_err
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_op;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_misalign;
    logic [2:0]        w_offset;
    logic              w_store;
    logic              w_done;
    logic [DATA_W-1:0] w_load_data;

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misalign = is_misaligned(req_addr[2:0], req_op[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_addr  <= '0;
            r_op    <= '0;
            r_rd    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_op    <= req_op;
                        r_rd    <= req_rd;
                        r_wdata <= req_wdata;
                        r_err   <= w_misalign;
                        // A faulting access never reaches the bus.
                        r_state <= w_misalign ? c_st_done : c_st_req;
                    end
                end
                c_st_req: begin
                    if (mem_req_ready) r_state <= c_st_wait;
                end
                c_st_wait: begin
                    if (mem_rsp_valid) begin
                        r_rdata <= mem_rsp_rdata;
                        r_state <= c_st_done;
                    end
                end
                default: begin
                    r_err   <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign w_offset = r_addr[2:0];
    assign w_store  = r_op[c_op_store_bit];
    assign w_done   = rst_n && (r_state == c_st_done);

    lsu_ext u_lsu_ext (
        .rdata  (r_rdata),
        .offset (w_offset),
        .size   (r_op[1:0]),
        .uns    (r_op[c_op_uns_bit]),
        .data   (w_load_data)
    );

    assign req_ready     = rst_n && (r_state == c_st_idle);
    assign mem_req_valid = rst_n && (r_state == c_st_req);
    assign mem_req_addr  = {r_addr[ADDR_W-1:3], 3'b000};
    assign mem_req_we    = w_store;
    // Strobes shifted past lane 7 fall off the 8-bit result.
    assign mem_req_wstrb = size_mask(r_op[1:0]) << w_offset;
    assign mem_req_wdata = r_wdata << {w_offset, 3'b000};

    assign wb_valid = w_done;
    assign wb_err   = w_done && r_err;
    assign wb_we    = w_done && !w_store && !r_err;
    assign wb_rd    = w_done ? r_rd : 5'd0;
    assign wb_data  = wb_we ? w_load_data : '0;

endmodule
`default_nettype wire
